// File: rtl/pio_cordic_pkg.sv
// Shared constants, FSM encoding and arctangent table for the PIO-driven CORDIC engine.
package pio_cordic_pkg;

    localparam int ANGLE_W = 16;
    localparam int DATA_W  = 16;

    // CORDIC gain compensation 1/1.6468 in Q1.15
    localparam logic [15:0] CORDIC_K = 16'h4DBA;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        DONE = 2'd2
    } cordic_state_t;

    // round(atan(2^-i) * 2^15 / pi), binary-angle units where 0x8000 is pi
    localparam logic [15:0] ATAN_TAB [0:15] = '{
        16'd8192, 16'd4836, 16'd2555, 16'd1297,
        16'd651,  16'd326,  16'd163,  16'd81,
        16'd41,   16'd20,   16'd10,   16'd5,
        16'd3,    16'd1,    16'd1,    16'd0
    };

    // Angles outside [-pi/2, +pi/2) are folded by a half-turn before rotating
    function automatic logic needs_half_turn(input logic [ANGLE_W-1:0] angle);
        return angle[ANGLE_W-1] ^ angle[ANGLE_W-2];
    endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup: iteration index to binary-angle step.
module cordic_atan_rom
    import pio_cordic_pkg::*;
(
    input  logic [3:0]  i_idx,
    output logic [15:0] o_atan
);

    assign o_atan = ATAN_TAB[i_idx];

endmodule

// File: rtl/pio_cordic_engine.sv
// Iterative rotation-mode CORDIC producing {sin,cos} from a PIO command word.
module pio_cordic_engine
    import pio_cordic_pkg::*;
#(
    parameter int ITER  = 16,
    parameter int GUARD = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] pio_cmd,
    output logic [31:0] result,
    output logic        busy,
    output logic        done_tog,
    output logic [1:0]  o_dbg_state
);

    // Command handshake: a command is offered whenever pio_cmd[31] differs from
    // the last accepted go bit and is taken only in IDLE; completion is signalled
    // by done_tog taking that go bit on the same edge result updates and busy drops.

    // One headroom bit above DATA_W+GUARD so the near-unity CORDIC gain cannot wrap
    localparam int XY_W  = DATA_W + GUARD + 1;
    localparam int Z_W   = ANGLE_W + 1;
    localparam int CNT_W = 5;

    localparam logic [CNT_W-1:0]       LAST_CNT = CNT_W'(ITER);
    localparam logic signed [XY_W-1:0] K_XY     = XY_W'(int'(CORDIC_K) * (2 ** GUARD));
    localparam logic signed [XY_W-1:0] SAT_POS  = XY_W'(32767);
    localparam logic signed [XY_W-1:0] SAT_NEG  = -SAT_POS;

    cordic_state_t           r_state;
    cordic_state_t           w_state_nxt;
    logic                    r_go_seen;
    logic [CNT_W-1:0]        r_cnt;
    logic signed [XY_W-1:0]  r_x;
    logic signed [XY_W-1:0]  r_y;
    logic signed [Z_W-1:0]   r_z;
    logic [31:0]             r_result;
    logic                    r_busy;
    logic                    r_done_tog;

    logic                    w_accept;
    logic                    w_rotate;
    logic                    w_finish;
    logic                    w_pre;
    logic [ANGLE_W-1:0]      w_z0_raw;
    logic signed [Z_W-1:0]   w_z0;
    logic signed [XY_W-1:0]  w_x0;
    logic [15:0]             w_atan;
    logic signed [Z_W-1:0]   w_atan_ext;
    logic                    w_d_pos;
    logic signed [XY_W-1:0]  w_x_sh;
    logic signed [XY_W-1:0]  w_y_sh;
    logic signed [XY_W-1:0]  w_x_nxt;
    logic signed [XY_W-1:0]  w_y_nxt;
    logic signed [Z_W-1:0]   w_z_nxt;
    logic signed [XY_W-1:0]  w_x_out;
    logic signed [XY_W-1:0]  w_y_out;
    logic                    w_unused_bits;

    assign w_unused_bits = ^pio_cmd[30:16];

    function automatic logic [15:0] sat_q15(input logic signed [XY_W-1:0] v);
        logic [15:0] q;
        if (v > SAT_POS) begin
            q = 16'h7FFF;
        end else if (v < SAT_NEG) begin
            q = 16'h8001;
        end else begin
            q = v[15:0];
        end
        return q;
    endfunction

    cordic_atan_rom u_atan_rom (
        .i_idx  (r_cnt[3:0]),
        .o_atan (w_atan)
    );

    // Pre-rotation is taken straight from the command word at the accepting edge
    assign w_pre    = needs_half_turn(pio_cmd[ANGLE_W-1:0]);
    assign w_z0_raw = w_pre ? (pio_cmd[ANGLE_W-1:0] + 16'h8000) : pio_cmd[ANGLE_W-1:0];
    assign w_z0     = {w_z0_raw[ANGLE_W-1], w_z0_raw};
    assign w_x0     = w_pre ? -K_XY : K_XY;

    assign w_atan_ext = {1'b0, w_atan};
    assign w_d_pos    = ~r_z[Z_W-1];
    assign w_x_sh     = r_x >>> r_cnt[3:0];
    assign w_y_sh     = r_y >>> r_cnt[3:0];
    assign w_x_nxt    = w_d_pos ? (r_x - w_y_sh) : (r_x + w_y_sh);
    assign w_y_nxt    = w_d_pos ? (r_y + w_x_sh) : (r_y - w_x_sh);
    assign w_z_nxt    = w_d_pos ? (r_z - w_atan_ext) : (r_z + w_atan_ext);

    assign w_x_out = r_x >>> GUARD;
    assign w_y_out = r_y >>> GUARD;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ROT holds one settle cycle once the counter reaches ITER, giving ITER+2 latency
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_rotate    = 1'b0;
        w_finish    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (pio_cmd[31] != r_go_seen) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ROT;
                end
            end
            ROT: begin
                if (r_cnt == LAST_CNT) begin
                    w_state_nxt = DONE;
                end else begin
                    w_rotate = 1'b1;
                end
            end
            DONE: begin
                w_finish    = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_go_seen  <= 1'b0;
            r_cnt      <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_z        <= '0;
            r_result   <= '0;
            r_busy     <= 1'b0;
            r_done_tog <= 1'b0;
        end else begin
            if (w_accept) begin
                r_go_seen <= pio_cmd[31];
                r_x       <= w_x0;
                r_y       <= '0;
                r_z       <= w_z0;
                r_cnt     <= '0;
                r_busy    <= 1'b1;
            end
            if (w_rotate) begin
                r_x   <= w_x_nxt;
                r_y   <= w_y_nxt;
                r_z   <= w_z_nxt;
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_finish) begin
                r_result   <= {sat_q15(w_y_out), sat_q15(w_x_out)};
                r_done_tog <= r_go_seen;
                r_busy     <= 1'b0;
            end
        end
    end

    assign result      = r_result;
    assign busy        = r_busy;
    assign done_tog    = r_done_tog;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pio_cordic_engine.sv
// Self-checking bench: two engines (ITER=16 and ITER=8) against a real-valued model.
module tb_pio_cordic_engine;

    localparam real PI = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [31:0] pio_cmd = 32'h0;

    logic [31:0] result16, result8;
    logic        busy16, busy8;
    logic        tog16, tog8;
    logic [1:0]  state16, state8;

    int n_err = 0;
    int n_chk = 0;

    int atan_tab [16] = '{8192, 4836, 2555, 1297, 651, 326, 163, 81,
                          41, 20, 10, 5, 3, 1, 1, 0};

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    pio_cordic_engine #(.ITER(16), .GUARD(2)) u_dut16 (
        .clk         (clk),
        .reset_n     (reset_n),
        .pio_cmd     (pio_cmd),
        .result      (result16),
        .busy        (busy16),
        .done_tog    (tog16),
        .o_dbg_state (state16)
    );

    pio_cordic_engine #(.ITER(8), .GUARD(2)) u_dut8 (
        .clk         (clk),
        .reset_n     (reset_n),
        .pio_cmd     (pio_cmd),
        .result      (result8),
        .busy        (busy8),
        .done_tog    (tog8),
        .o_dbg_state (state8)
    );

    // ---------------- reference model ----------------
    function automatic int clamp_q15(input real v);
        int r;
        r = int'(v);
        if (r > 32767) r = 32767;
        if (r < -32767) r = -32767;
        return r;
    endfunction

    function automatic void ideal_sc(input logic [15:0] a, output int s, output int c);
        real th;
        th = real'($signed(a)) * PI / 32768.0;
        s = clamp_q15($sin(th) * 32768.0);
        c = clamp_q15($cos(th) * 32768.0);
    endfunction

    // Exact rotation by the micro-angles the table-driven decisions select, with exact gain
    function automatic void cordic_sc(input logic [15:0] a, input int n, output int s, output int c);
        real th, g, t;
        int  z;
        logic [15:0] a2;
        if (a[15] != a[14]) begin
            th = PI;
            a2 = a + 16'h8000;
        end else begin
            th = 0.0;
            a2 = a;
        end
        z = int'($signed(a2));
        g = 19898.0 / 32768.0;
        for (int i = 0; i < n; i++) begin
            t = 1.0 / real'(1 << i);
            if (z >= 0) begin
                z  = z - atan_tab[i];
                th = th + $atan(t);
            end else begin
                z  = z + atan_tab[i];
                th = th - $atan(t);
            end
            g = g * $sqrt(1.0 + t * t);
        end
        s = clamp_q15(g * $sin(th) * 32768.0);
        c = clamp_q15(g * $cos(th) * 32768.0);
    endfunction

    // Transaction model per engine: k=0 is ITER=16, k=1 is ITER=8
    int          iters [2] = '{16, 8};
    int          tols  [2] = '{4, 300};
    logic        m_busy [2];
    logic        m_go   [2];
    logic        m_tog  [2];
    int          m_rem  [2];
    logic [15:0] m_ang  [2];
    int          m_s    [2];
    int          m_c    [2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 0; m_go[k] = 0; m_tog[k] = 0; m_rem[k] = 0;
            m_ang[k] = 0; m_s[k] = 0; m_c[k] = 0;
        end
        forever begin
            @(posedge clk or negedge reset_n);
            for (int k = 0; k < 2; k++) begin
                if (!reset_n) begin
                    m_busy[k] = 0; m_go[k] = 0; m_tog[k] = 0; m_rem[k] = 0;
                    m_s[k] = 0; m_c[k] = 0;
                end else if (m_busy[k]) begin
                    m_rem[k] = m_rem[k] - 1;
                    if (m_rem[k] == 0) begin
                        m_busy[k] = 0;
                        m_tog[k]  = m_go[k];
                        if (k == 0) cordic_sc(m_ang[k], iters[k], m_s[k], m_c[k]);
                        else        ideal_sc(m_ang[k], m_s[k], m_c[k]);
                    end
                end else if (pio_cmd[31] != m_go[k]) begin
                    m_go[k]   = pio_cmd[31];
                    m_ang[k]  = pio_cmd[15:0];
                    m_busy[k] = 1;
                    m_rem[k]  = iters[k] + 2;
                end
            end
        end
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check_near(input string nm, input int act, input int exp, input int tol);
        int d;
        n_chk++;
        d = act - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d, want %0d +/- %0d", nm, $time, act, exp, tol);
        end
    endtask

    task automatic check_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%08h, want 0x%08h", nm, $time, act, exp);
        end
    endtask

    function automatic int sin_of(input logic [31:0] r);
        return int'($signed(r[31:16]));
    endfunction

    function automatic int cos_of(input logic [31:0] r);
        return int'($signed(r[15:0]));
    endfunction

    // Per-cycle compare of both engines against the model
    initial begin
        logic [31:0] r;
        logic        b, d;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (k == 0) begin r = result16; b = busy16; d = tog16; end
                else        begin r = result8;  b = busy8;  d = tog8;  end
                check_eq($sformatf("cyc_busy[%0d]", k), {31'h0, b}, {31'h0, m_busy[k]});
                check_eq($sformatf("cyc_done_tog[%0d]", k), {31'h0, d}, {31'h0, m_tog[k]});
                check_near($sformatf("cyc_sin[%0d] ang=0x%04h", k, m_ang[k]), sin_of(r), m_s[k], tols[k]);
                check_near($sformatf("cyc_cos[%0d] ang=0x%04h", k, m_ang[k]), cos_of(r), m_c[k], tols[k]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [15:0] ang);
        @(negedge clk);
        pio_cmd = {~pio_cmd[31], 15'h0, ang};
    endtask

    task automatic wait_idle16(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy16 && n < budget);
        if (busy16) begin
            n_chk++; n_err++;
            $display("FAIL wait_idle16: busy still 1 after %0d cycles, want 0", budget);
        end
    endtask

    task automatic wait_all(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy16 || busy8) && n < budget);
        if (busy16 || busy8) begin
            n_chk++; n_err++;
            $display("FAIL wait_all: busy16=%0b busy8=%0b after %0d cycles, want 0", busy16, busy8, budget);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int s, c, nb;
        logic [15:0] edge_angles [6];
        edge_angles = '{16'h7FFF, 16'h8001, 16'h3FFF, 16'h4000, 16'hBFFF, 16'hC000};

        // Pin the model against hand-computed values
        ideal_sc(16'h2000, s, c);
        check_near("model_ideal_sin_pi4", s, 23170, 0);
        ideal_sc(16'hC000, s, c);
        check_near("model_ideal_sin_mpi2", s, -32767, 0);
        cordic_sc(16'h0000, 16, s, c);
        check_near("model_cordic_cos_0", c, 32767, 2);
        check_near("model_cordic_sin_0", s, 0, 4);
        cordic_sc(16'h4000, 16, s, c);
        check_near("model_cordic_sin_pi2", s, 32767, 4);

        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_result", result16, 32'h0);
        check_eq("reset_busy", {31'h0, busy16}, 32'h0);
        check_eq("reset_done_tog", {31'h0, tog16}, 32'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: angle 0, busy width
        send(16'h0000);
        nb = 0;
        @(negedge clk);
        while (busy16 && nb < 100) begin
            nb++;
            @(negedge clk);
        end
        check_near("t1_busy_cycles", nb, 18, 0);
        check_near("t1_cos", cos_of(result16), 32767, 4);
        check_near("t1_sin", sin_of(result16), 0, 4);
        check_eq("t1_done_tog", {31'h0, tog16}, 32'h1);
        wait_all(60);

        // 2: pi/4 with go toggled back
        send(16'h2000);
        wait_all(60);
        check_near("t2_sin", sin_of(result16), 23170, 4);
        check_near("t2_cos", cos_of(result16), 23170, 4);
        check_eq("t2_done_tog", {31'h0, tog16}, 32'h0);

        // 3: pre-rotation corners
        send(16'h4000); wait_all(60);
        check_near("t3_p90_sin", sin_of(result16), 32767, 4);
        check_near("t3_p90_cos", cos_of(result16), 0, 4);
        send(16'hC000); wait_all(60);
        check_near("t3_m90_sin", sin_of(result16), -32767, 4);
        check_near("t3_m90_cos", cos_of(result16), 0, 4);
        check_near("t3_m90_nosat", (result16[31:16] == 16'h8000) ? 1 : 0, 0, 0);
        send(16'h8000); wait_all(60);
        check_near("t3_m180_cos", cos_of(result16), -32767, 4);
        check_near("t3_m180_sin", sin_of(result16), 0, 4);
        check_near("t3_m180_nosat", (result16[15:0] == 16'h8000) ? 1 : 0, 0, 0);

        // 4a: angle change without go toggle is ignored
        @(negedge clk);
        pio_cmd = {pio_cmd[31], 15'h0, 16'h1234};
        repeat (25) @(negedge clk);
        check_eq("t4_no_run_busy", {31'h0, busy16}, 32'h0);
        check_near("t4_held_cos", cos_of(result16), -32767, 4);

        // 4b: single toggle mid-run queues one more run
        send(16'h0000);
        repeat (5) @(negedge clk);
        send(16'h4000);
        wait_idle16(60);
        @(negedge clk);
        check_eq("t4_queued_started", {31'h0, busy16}, 32'h1);
        wait_all(60);
        check_near("t4_queued_sin", sin_of(result16), 32767, 4);

        // 4c: double toggle mid-run cancels out
        send(16'h2000);
        repeat (3) @(negedge clk);
        pio_cmd = {~pio_cmd[31], 15'h0, 16'h6000};
        repeat (3) @(negedge clk);
        pio_cmd = {~pio_cmd[31], 15'h0, 16'h6000};
        wait_idle16(60);
        repeat (25) @(negedge clk);
        check_eq("t4_double_no_run", {31'h0, busy16}, 32'h0);
        check_near("t4_double_sin", sin_of(result16), 23170, 4);

        // 5: asynchronous reset at rotation iteration 7
        send(16'h1000);
        repeat (9) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_eq("t5_rst_busy", {31'h0, busy16}, 32'h0);
        check_eq("t5_rst_result", result16, 32'h0);
        check_eq("t5_rst_done_tog", {31'h0, tog16}, 32'h0);
        pio_cmd = 32'h0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (25) @(negedge clk);
        check_eq("t5_post_busy", {31'h0, busy16}, 32'h0);
        check_eq("t5_post_result", result16, 32'h0);

        // 6: boundary angles then random sweep, both ITER variants
        for (int i = 0; i < 1006; i++) begin
            if (i < 6) send(edge_angles[i]);
            else       send(16'($urandom_range(0, 65535)));
            wait_all(60);
        end
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
